// File: rtl/recon_bitstream_reader_pkg.sv
// rtl/recon_bitstream_reader_pkg.sv - shared AXI encodings, boundary constant and FSM state type
package recon_bitstream_reader_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam int         BOUNDARY_4K    = 4096;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_DONE
    } rd_state_t;

endpackage

// File: rtl/recon_bitstream_reader_axis_out_reg.sv
// rtl/recon_bitstream_reader_axis_out_reg.sv - one-entry AXIS register with registered valid
module recon_axis_out_reg #(
    parameter int DATA_WIDTH = 512,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic [KEEP_WIDTH-1:0] s_tkeep,
    input  logic                  s_tlast,
    input  logic                  s_tuser,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic [KEEP_WIDTH-1:0] m_tkeep,
    output logic                  m_tlast,
    output logic                  m_tuser,
    output logic                  m_tvalid,
    input  logic                  m_tready
);

    // Accepting while the held beat leaves lets the register reload without a bubble.
    assign s_tready = !m_tvalid || m_tready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_tdata  <= '0;
            m_tkeep  <= '0;
            m_tlast  <= 1'b0;
            m_tuser  <= 1'b0;
            m_tvalid <= 1'b0;
        end else if (s_tvalid && s_tready) begin
            m_tdata  <= s_tdata;
            m_tkeep  <= s_tkeep;
            m_tlast  <= s_tlast;
            m_tuser  <= s_tuser;
            m_tvalid <= 1'b1;
        end else if (m_tready) begin
            m_tvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/recon_bitstream_reader.sv
// rtl/recon_bitstream_reader.sv - reads a stored bitstream region over AXI4 AR/R and emits one AXIS frame
module recon_bitstream_reader
    import recon_bitstream_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 512,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int ADDR_WIDTH = 34,
    parameter int ID_WIDTH   = 6,
    parameter int LEN_WIDTH  = 32,
    parameter int MAX_BURST  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    output logic [ID_WIDTH-1:0]   m_axi_arid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [ID_WIDTH-1:0]   m_axi_rid,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int BSHIFT = $clog2(KEEP_WIDTH);

    rd_state_t             state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LEN_WIDTH-1:0]  beats_left;
    logic [LEN_WIDTH-1:0]  beat_cnt;
    logic [KEEP_WIDTH-1:0] last_keep;
    logic [8:0]            burst_left;
    logic                  resp_err;
    logic                  err_q;

    logic [LEN_WIDTH-1:0]  cmd_beats;
    logic [KEEP_WIDTH-1:0] cmd_keep;
    logic [12:0]           to_bound;
    logic [LEN_WIDTH-1:0]  burst;
    logic                  r_hs;
    logic                  last_beat;
    logic                  rresp_bad;
    logic                  out_ready;
    logic                  unused_sig;

    assign cmd_beats = (cmd_len >> BSHIFT) + LEN_WIDTH'(|cmd_len[BSHIFT-1:0]);
    assign cmd_keep  = (cmd_len[BSHIFT-1:0] == '0) ? {KEEP_WIDTH{1'b1}}
                                                   : ~({KEEP_WIDTH{1'b1}} << cmd_len[BSHIFT-1:0]);

    // Beats left before the next 4 KiB page; addr_q is always beat-aligned.
    assign to_bound = (13'(BOUNDARY_4K) - {1'b0, addr_q[11:0]}) >> BSHIFT;

    always_comb begin
        burst = LEN_WIDTH'(MAX_BURST);
        if (beats_left < burst)
            burst = beats_left;
        if (LEN_WIDTH'(to_bound) < burst)
            burst = LEN_WIDTH'(to_bound);
    end

    assign cmd_ready     = (state == ST_IDLE);
    assign busy          = (state == ST_ADDR) || (state == ST_DATA);
    assign done          = (state == ST_DONE);
    assign err           = err_q;

    assign m_axi_arid    = '0;
    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = (state == ST_ADDR) ? 8'(burst - LEN_WIDTH'(1)) : 8'd0;
    assign m_axi_arsize  = 3'(BSHIFT);
    assign m_axi_arburst = AXI_BURST_INCR;
    assign m_axi_arvalid = (state == ST_ADDR);
    assign m_axi_rready  = (state == ST_DATA) && out_ready;

    assign r_hs      = m_axi_rvalid && m_axi_rready;
    assign last_beat = (beats_left == LEN_WIDTH'(1));
    assign rresp_bad = (m_axi_rresp != AXI_RESP_OKAY);

    assign unused_sig = ^{m_axi_rid, cmd_addr[BSHIFT-1:0], beat_cnt};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            addr_q     <= '0;
            beats_left <= '0;
            beat_cnt   <= '0;
            last_keep  <= '0;
            burst_left <= '0;
            resp_err   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        addr_q     <= {cmd_addr[ADDR_WIDTH-1:BSHIFT], {BSHIFT{1'b0}}};
                        beats_left <= cmd_beats;
                        last_keep  <= cmd_keep;
                        beat_cnt   <= '0;
                        resp_err   <= 1'b0;
                        err_q      <= 1'b0;
                        state      <= (cmd_len == '0) ? ST_DONE : ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (m_axi_arready) begin
                        addr_q     <= addr_q + ADDR_WIDTH'(burst << BSHIFT);
                        burst_left <= 9'(burst);
                        state      <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (r_hs) begin
                        beats_left <= beats_left - LEN_WIDTH'(1);
                        beat_cnt   <= beat_cnt + LEN_WIDTH'(1);
                        burst_left <= burst_left - 9'd1;
                        if (rresp_bad) begin
                            resp_err <= 1'b1;
                            err_q    <= 1'b1;
                        end
                        // The issued arlen decides where the burst ends; rlast is only cross-checked.
                        if (m_axi_rlast != (burst_left == 9'd1))
                            err_q <= 1'b1;
                        if (burst_left == 9'd1)
                            state <= last_beat ? ST_DONE : ST_ADDR;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    recon_axis_out_reg #(
        .DATA_WIDTH (DATA_WIDTH),
        .KEEP_WIDTH (KEEP_WIDTH)
    ) u_out_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_tdata  (m_axi_rdata),
        .s_tkeep  (last_beat ? last_keep : {KEEP_WIDTH{1'b1}}),
        .s_tlast  (last_beat),
        .s_tuser  (last_beat && (resp_err || rresp_bad)),
        .s_tvalid (r_hs),
        .s_tready (out_ready),
        .m_tdata  (m_axis_tdata),
        .m_tkeep  (m_axis_tkeep),
        .m_tlast  (m_axis_tlast),
        .m_tuser  (m_axis_tuser),
        .m_tvalid (m_axis_tvalid),
        .m_tready (m_axis_tready)
    );

endmodule

// File: tb/tb_recon_bitstream_reader.sv
// tb/tb_recon_bitstream_reader.sv - directed self-checking bench for recon_bitstream_reader
module tb_recon_bitstream_reader;

    localparam int DW = 512;
    localparam int KW = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic [33:0]   cmd_addr;
    logic [31:0]   cmd_len;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [5:0]    m_axi_arid;
    logic [33:0]   m_axi_araddr;
    logic [7:0]    m_axi_arlen;
    logic [2:0]    m_axi_arsize;
    logic [1:0]    m_axi_arburst;
    logic          m_axi_arvalid;
    logic          m_axi_arready;
    logic [5:0]    m_axi_rid;
    logic [DW-1:0] m_axi_rdata;
    logic [1:0]    m_axi_rresp;
    logic          m_axi_rlast;
    logic          m_axi_rvalid;
    logic          m_axi_rready;
    logic [DW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic          m_axis_tlast;
    logic          m_axis_tuser;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          busy;
    logic          done;
    logic          err;

    recon_bitstream_reader dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_addr      (cmd_addr),
        .cmd_len       (cmd_len),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .m_axi_arid    (m_axi_arid),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arlen   (m_axi_arlen),
        .m_axi_arsize  (m_axi_arsize),
        .m_axi_arburst (m_axi_arburst),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_rid     (m_axi_rid),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rlast   (m_axi_rlast),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    int passed = 0;
    int total  = 0;
    int bi, ai, d0;

    logic [DW-1:0] mon_data[$];
    logic [KW-1:0] mon_keep[$];
    logic          mon_last[$];
    logic          mon_user[$];
    logic [33:0]   ar_addr_q[$];
    logic [7:0]    ar_len_q[$];
    int            done_cnt = 0;

    bit tready_rnd = 1'b0;
    int err_beat   = -1;

    function automatic logic [DW-1:0] pat(input logic [33:0] a);
        logic [31:0] w;
        w = a[31:0] ^ 32'hC0DE_0000;
        return {16{w}};
    endfunction

    // Memory slave: one outstanding burst, data derived from the beat address.
    logic [33:0] s_addr;
    int          s_left;
    int          s_beat;
    assign m_axi_rid = '0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_axi_arready <= 1'b0;
            m_axi_rvalid  <= 1'b0;
            m_axi_rlast   <= 1'b0;
            m_axi_rresp   <= 2'b00;
            m_axi_rdata   <= '0;
            s_addr = '0;
            s_left = 0;
            s_beat = 0;
        end else begin
            m_axi_arready <= ($urandom_range(0, 3) != 0);
            if (cmd_valid && cmd_ready)
                s_beat = 0;
            if (m_axi_arvalid && m_axi_arready) begin
                ar_addr_q.push_back(m_axi_araddr);
                ar_len_q.push_back(m_axi_arlen);
                s_addr = m_axi_araddr;
                s_left = int'(m_axi_arlen) + 1;
            end
            if (!m_axi_rvalid || m_axi_rready) begin
                if (s_left > 0) begin
                    m_axi_rvalid <= 1'b1;
                    m_axi_rdata  <= pat(s_addr);
                    m_axi_rresp  <= (s_beat == err_beat) ? 2'b10 : 2'b00;
                    m_axi_rlast  <= (s_left == 1);
                    s_addr = s_addr + 34'd64;
                    s_left--;
                    s_beat++;
                end else begin
                    m_axi_rvalid <= 1'b0;
                    m_axi_rlast  <= 1'b0;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rst_n && m_axis_tvalid && m_axis_tready) begin
            mon_data.push_back(m_axis_tdata);
            mon_keep.push_back(m_axis_tkeep);
            mon_last.push_back(m_axis_tlast);
            mon_user.push_back(m_axis_tuser);
        end
        if (rst_n && done)
            done_cnt++;
    end

    always @(negedge clk)
        m_axis_tready = tready_rnd ? ($urandom_range(0, 9) >= 3) : 1'b1;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic send_cmd(input logic [33:0] a, input logic [31:0] l);
        @(negedge clk);
        cmd_addr  = a;
        cmd_len   = l;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int start, input int budget);
        int n = 0;
        while (done_cnt == start && n < budget) begin
            @(negedge clk);
            n++;
        end
        repeat (24) @(negedge clk);
        chk("done_once", 32'(done_cnt - start), 32'd1);
    endtask

    task automatic check_stream(input string tag, input int b0, input int n,
                                input logic [33:0] base, input logic [KW-1:0] lkeep, input logic luser);
        chk({tag, "_beats"}, 32'(mon_data.size() - b0), 32'(n));
        for (int i = 0; i < n && b0 + i < mon_data.size(); i++) begin
            chk($sformatf("%s_data%0d", tag, i), mon_data[b0+i], pat(base + 34'(i * 64)));
            chk($sformatf("%s_keep%0d", tag, i), mon_keep[b0+i], (i == n - 1) ? lkeep : {KW{1'b1}});
            chk($sformatf("%s_last%0d", tag, i), mon_last[b0+i], (i == n - 1));
            chk($sformatf("%s_user%0d", tag, i), mon_user[b0+i], (i == n - 1) && luser);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [33:0] t2_addr [5];
        logic [7:0]  t2_len  [5];
        t2_addr = '{34'h0FC0, 34'h1000, 34'h1400, 34'h1800, 34'h1C00};
        t2_len  = '{8'd0, 8'd15, 8'd15, 8'd15, 8'd14};

        rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_addr = '0;
        cmd_len = '0;
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_arvalid", m_axi_arvalid, 0);
        chk("rst_rready", m_axi_rready, 0);
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_tlast", m_axis_tlast, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // T1: 200 bytes from 0x1000 -> one 4-beat burst, last keep 8 bytes
        bi = mon_data.size(); ai = ar_addr_q.size(); d0 = done_cnt;
        send_cmd(34'h1000, 32'd200);
        chk("t1_arvalid", m_axi_arvalid, 1);
        chk("t1_araddr", m_axi_araddr, 34'h1000);
        chk("t1_arlen", m_axi_arlen, 3);
        chk("t1_arsize", m_axi_arsize, 6);
        chk("t1_arburst", m_axi_arburst, 1);
        chk("t1_arid", m_axi_arid, 0);
        chk("t1_busy", busy, 1);
        chk("t1_cmd_ready", cmd_ready, 0);
        wait_done(d0, 500);
        chk("t1_ar_count", 32'(ar_addr_q.size() - ai), 1);
        check_stream("t1", bi, 4, 34'h1000, 64'hFF, 1'b0);
        chk("t1_err", err, 0);
        chk("t1_idle", cmd_ready, 1);

        // T2: 4096 bytes from 0x0FC0 -> 1-beat burst to the page edge, then 16,16,16,15
        bi = mon_data.size(); ai = ar_addr_q.size(); d0 = done_cnt;
        send_cmd(34'h0FC0, 32'd4096);
        wait_done(d0, 2000);
        chk("t2_ar_count", 32'(ar_addr_q.size() - ai), 5);
        for (int i = 0; i < 5 && ai + i < ar_addr_q.size(); i++) begin
            chk($sformatf("t2_araddr%0d", i), ar_addr_q[ai+i], t2_addr[i]);
            chk($sformatf("t2_arlen%0d", i), ar_len_q[ai+i], t2_len[i]);
        end
        check_stream("t2", bi, 64, 34'h0FC0, {KW{1'b1}}, 1'b0);

        // T3: zero length -> straight to DONE, no AR, no beat
        bi = mon_data.size(); ai = ar_addr_q.size(); d0 = done_cnt;
        send_cmd(34'h6000, 32'd0);
        chk("t3_done", done, 1);
        chk("t3_busy", busy, 0);
        chk("t3_cmd_ready_done", cmd_ready, 0);
        chk("t3_arvalid", m_axi_arvalid, 0);
        @(negedge clk);
        chk("t3_cmd_ready_next", cmd_ready, 1);
        chk("t3_done_next", done, 0);
        repeat (10) @(negedge clk);
        chk("t3_ar_count", 32'(ar_addr_q.size() - ai), 0);
        chk("t3_beats", 32'(mon_data.size() - bi), 0);
        chk("t3_done_count", 32'(done_cnt - d0), 1);

        // T4: 1000 bytes under random backpressure -> 16 beats, last keep 40 bytes
        tready_rnd = 1'b1;
        bi = mon_data.size(); ai = ar_addr_q.size(); d0 = done_cnt;
        send_cmd(34'h2000, 32'd1000);
        wait_done(d0, 2000);
        chk("t4_ar_count", 32'(ar_addr_q.size() - ai), 1);
        if (ar_len_q.size() > ai)
            chk("t4_arlen", ar_len_q[ai], 15);
        check_stream("t4", bi, 16, 34'h2000, 64'h0000_00FF_FFFF_FFFF, 1'b0);
        tready_rnd = 1'b0;

        // T5: SLVERR on the second of four beats -> data forwarded, tuser on tlast, sticky err
        err_beat = 1;
        bi = mon_data.size(); d0 = done_cnt;
        send_cmd(34'h3000, 32'd256);
        wait_done(d0, 500);
        check_stream("t5", bi, 4, 34'h3000, {KW{1'b1}}, 1'b1);
        chk("t5_err_sticky", err, 1);
        err_beat = -1;

        // T6: reset in the middle of a transfer, then a clean command
        send_cmd(34'h4000, 32'd2048);
        chk("t6_err_cleared", err, 0);
        repeat (6) @(negedge clk);
        chk("t6_busy_mid", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_cmd_ready", cmd_ready, 1);
        chk("t6_rst_arvalid", m_axi_arvalid, 0);
        chk("t6_rst_rready", m_axi_rready, 0);
        chk("t6_rst_tvalid", m_axis_tvalid, 0);
        chk("t6_rst_tlast", m_axis_tlast, 0);
        chk("t6_rst_tuser", m_axis_tuser, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_done", done, 0);
        chk("t6_rst_err", err, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bi = mon_data.size(); ai = ar_addr_q.size(); d0 = done_cnt;
        send_cmd(34'h5000, 32'd128);
        wait_done(d0, 500);
        chk("t6_ar_count", 32'(ar_addr_q.size() - ai), 1);
        if (ar_len_q.size() > ai)
            chk("t6_arlen", ar_len_q[ai], 1);
        check_stream("t6", bi, 2, 34'h5000, {KW{1'b1}}, 1'b0);
        chk("t6_err", err, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
